bcd_mmss_timer: RTL
===================

# bcd_mmss_timer

- Parametrised MM:SS kitchen-timer core.
- Holds four BCD digits (minutes upper/lower, seconds upper/lower).
- Counts up or down once per TICK_DIV clock cycles, with load, start, stop and clear controls.
- Drives the display driver's digit inputs and produces an expiry pulse for the alarm/buzzer path.

## Interface
- TICK_DIV, 100: clock cycles per one-second tick; legal range 2..2^24.
- WRAP_UP, 0: count-up behaviour at 59:59. 1 = wrap to 00:00 and keep running. 0 = saturate at 59:59 and expire.
- CLK  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  pulse; zero the digits, prescaler and alarm; go to IDLE.
- load  in  1  pulse; capture the load digits.
- start  in  1  pulse; begin or resume counting.
- stop  in  1  pulse; pause counting.
- dir  in  1  0 = count down, 1 = count up; sampled at every tick.
- minutes_upper_in, minutes_lower_in, seconds_upper_in, seconds_lower_in  in  4 each  BCD load value.
- minutes_upper, minutes_lower, seconds_upper, seconds_lower  out  4 each  current BCD value.
- running  out  1  high while in RUN.
- tick  out  1  one-cycle pulse on every counted second.
- done  out  1  one-cycle expiry pulse.
- alarm  out  1  sticky alarm; see Configuration.
- alarm_ack  in  1  clears alarm.

## Operation
- Reset values: all digits 0, prescaler 0, state IDLE, running 0, tick 0, done 0, alarm 0.
- States: IDLE, RUN, EXPIRED.
- Command priority within one cycle: clear > load > stop > start.
- clear, from any state:
  - zeroes the digits and prescaler;
  - goes to IDLE.
- load, in IDLE or EXPIRED:
  - captures the load digits;
  - clears the prescaler;
  - goes to IDLE.
  - Ignored in RUN.
- Load clamping: an upper digit above 5 loads as 5; a lower digit above 9 loads as 9. Example: load 7,C,6,3 -> 59:53.
- start, in IDLE:
  - goes to RUN;
  - ignored when dir=0 and the value is 00:00.
- start, in EXPIRED: behaves as in IDLE, including the 00:00 rule.
- stop, in RUN:
  - goes to IDLE;
  - the prescaler holds its value, so a resume finishes the partial second.
- Prescaler:
  - counts 0..TICK_DIV-1 in RUN only;
  - at TICK_DIV-1 it returns to 0 and a tick occurs.
- Down-count on tick:
  - BCD decrement with borrow chain seconds_lower (9->0) -> seconds_upper (5->0) -> minutes_lower (9->0) -> minutes_upper (5->0).
  - Reaching 00:00 -> EXPIRED with done.
- Up-count on tick:
  - BCD increment with the mirror carry chain.
  - At 59:59, WRAP_UP=1 -> 00:00 and stay in RUN.
  - At 59:59, WRAP_UP=0 -> stay at 59:59 and go to EXPIRED with done.
- dir change mid-run takes effect at the next tick. A dir=0 run passing through 00:00 expires as a normal down-count.
- EXPIRED holds the digits; running=0.

## Timing
- The tick pulse and digit update are registered together. Both are visible in the cycle after the prescaler edge in which it is at TICK_DIV-1.
- done asserts in the same cycle the final value (00:00 or the saturated 59:59) is first visible. It lasts exactly one cycle.
- running is a registered state decode:
  - rises the cycle after start;
  - falls the cycle after stop, clear, or expiry.
- First tick after start from prescaler 0: TICK_DIV cycles after the start edge.
- Asynchronous reset mid-run forces the reset values immediately. The first counting operation after reset deassertion requires a new start.

## Configuration
- KITCHEN_TIMER_ALARM_EN defined:
  - alarm sets on done;
  - clears on alarm_ack, clear, or an accepted start;
  - when done and alarm_ack coincide, the set wins.
- KITCHEN_TIMER_ALARM_EN undefined:
  - alarm is tied 0;
  - alarm_ack is ignored;
  - the port list is unchanged.

## Structure
- Package kitchen_timer_pkg holds:
  - the state enum (IDLE, RUN, EXPIRED);
  - BCD limits: SEC_UPPER_MAX=5, MIN_UPPER_MAX=5, LOWER_MAX=9;
  - the clamp function.
- Sub-module bcd_digit_ctr:
  - parameter MAX;
  - inputs inc, dec, load, load value;
  - outputs digit, carry, borrow.
  - Instantiated four times as a ripple chain.
- The top level holds the prescaler, state machine, and done/alarm logic.

## Test plan
Run with TICK_DIV=4.
- Load 00:03, dir=0, start -> ticks every 4 cycles; 00:02, 00:01, 00:00; done for one cycle with 00:00; EXPIRED; running=0.
- Load 01:00, dir=0, start, one tick -> 00:59 (borrow across all digits).
- Load 59:59, dir=1, start, WRAP_UP=0 -> done at the first tick, value stays 59:59. With WRAP_UP=1 -> 00:00, running stays 1, no done.
- Run, stop two cycles into a second, wait 20 cycles, start -> next tick two cycles after the resume; digits unchanged while paused.
- Same-cycle load+start in IDLE -> load only, stays IDLE. Load 7,C,6,3 -> 59:53. Load during RUN -> ignored. clear+load -> 00:00 IDLE.
- With KITCHEN_TIMER_ALARM_EN, expire -> alarm=1 until alarm_ack. Without it -> alarm=0 throughout. Reset asserted mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/kitchen_timer_pkg.sv
// rtl/kitchen_timer_pkg.sv - state type, BCD digit limits and load clamp for the MM:SS timer
package kitchen_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timer_state_t;

   localparam logic [3:0] SEC_UPPER_MAX = 4'd5;
   localparam logic [3:0] MIN_UPPER_MAX = 4'd5;
   localparam logic [3:0] LOWER_MAX     = 4'd9;

   function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// rtl/bcd_digit_ctr.sv - one BCD digit 0..MAX with load, increment and decrement
module bcd_digit_ctr
   import kitchen_timer_pkg::*;
#(
   parameter logic [3:0] MAX = LOWER_MAX
)(
   input  logic       CLK,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       carry,
   output logic       borrow
);

   // carry/borrow ripple to the next digit in the same cycle this digit wraps
   assign carry  = inc && (digit == MAX);
   assign borrow = dec && (digit == 4'd0);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         digit <= 4'd0;
      end else if (clear) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= load_value;
      end else if (inc) begin
         digit <= carry ? 4'd0 : digit + 4'd1;
      end else if (dec) begin
         digit <= borrow ? MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_mmss_timer.sv
// rtl/bcd_mmss_timer.sv - MM:SS BCD kitchen timer core; optional alarm under KITCHEN_TIMER_ALARM_EN
module bcd_mmss_timer
   import kitchen_timer_pkg::*;
#(
   parameter int TICK_DIV = 100,
   parameter int WRAP_UP  = 0
)(
   input  logic       CLK,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       start,
   input  logic       stop,
   input  logic       dir,
   input  logic [3:0] minutes_upper_in,
   input  logic [3:0] minutes_lower_in,
   input  logic [3:0] seconds_upper_in,
   input  logic [3:0] seconds_lower_in,
   output logic [3:0] minutes_upper,
   output logic [3:0] minutes_lower,
   output logic [3:0] seconds_upper,
   output logic [3:0] seconds_lower,
   output logic       running,
   output logic       tick,
   output logic       done,
   output logic       alarm,
   input  logic       alarm_ack
);

   localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);

   timer_state_t state, next_state;
   logic [23:0]  presc;
   logic [15:0]  value;
   logic         at_zero, at_one, at_max, saturate;
   logic         load_acc, stop_acc, start_acc;
   logic         tick_now, tick_inc, tick_dec, expire_now;
   logic         sl_carry, sl_borrow, su_carry, su_borrow, ml_carry, ml_borrow;
   logic         unused_mu_carry, unused_mu_borrow;
   logic [3:0]   ld_mu, ld_ml, ld_su, ld_sl;

   assign ld_mu = clamp_digit(minutes_upper_in, MIN_UPPER_MAX);
   assign ld_ml = clamp_digit(minutes_lower_in, LOWER_MAX);
   assign ld_su = clamp_digit(seconds_upper_in, SEC_UPPER_MAX);
   assign ld_sl = clamp_digit(seconds_lower_in, LOWER_MAX);

   assign value    = {minutes_upper, minutes_lower, seconds_upper, seconds_lower};
   assign at_zero  = (value == 16'h0000);
   assign at_one   = (value == 16'h0001);
   assign at_max   = (value == 16'h5959);
   assign saturate = at_max && (WRAP_UP == 0);

   always_comb begin
      load_acc   = load && !clear && (state != RUN);
      stop_acc   = stop && !clear && (state == RUN);
      start_acc  = start && !clear && !load_acc && !stop && (state != RUN) && !(!dir && at_zero);
      tick_now   = (state == RUN) && !clear && !stop && (presc == PRESC_LAST);
      tick_inc   = tick_now && dir && !saturate;
      // a down tick at 00:00 (reachable only after a mid-run dir flip) holds and expires
      tick_dec   = tick_now && !dir && !at_zero;
      expire_now = tick_now && (dir ? saturate : (at_zero || at_one));
      next_state = state;
      if (clear || load_acc || stop_acc) begin
         next_state = IDLE;
      end else if (start_acc) begin
         next_state = RUN;
      end else if (expire_now) begin
         next_state = EXPIRED;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         presc   <= 24'd0;
         running <= 1'b0;
         tick    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= next_state;
         running <= (next_state == RUN);
         tick    <= tick_now;
         done    <= expire_now;
         // stop leaves the prescaler untouched so a resume completes the partial second
         if (clear || load_acc || tick_now) begin
            presc <= 24'd0;
         end else if ((state == RUN) && !stop_acc) begin
            presc <= presc + 24'd1;
         end
      end
   end

   bcd_digit_ctr #(.MAX(LOWER_MAX)) u_sec_lower (
      .CLK(CLK), .reset(reset), .clear(clear), .load(load_acc), .load_value(ld_sl),
      .inc(tick_inc), .dec(tick_dec),
      .digit(seconds_lower), .carry(sl_carry), .borrow(sl_borrow)
   );

   bcd_digit_ctr #(.MAX(SEC_UPPER_MAX)) u_sec_upper (
      .CLK(CLK), .reset(reset), .clear(clear), .load(load_acc), .load_value(ld_su),
      .inc(sl_carry), .dec(sl_borrow),
      .digit(seconds_upper), .carry(su_carry), .borrow(su_borrow)
   );

   bcd_digit_ctr #(.MAX(LOWER_MAX)) u_min_lower (
      .CLK(CLK), .reset(reset), .clear(clear), .load(load_acc), .load_value(ld_ml),
      .inc(su_carry), .dec(su_borrow),
      .digit(minutes_lower), .carry(ml_carry), .borrow(ml_borrow)
   );

   bcd_digit_ctr #(.MAX(MIN_UPPER_MAX)) u_min_upper (
      .CLK(CLK), .reset(reset), .clear(clear), .load(load_acc), .load_value(ld_mu),
      .inc(ml_carry), .dec(ml_borrow),
      .digit(minutes_upper), .carry(unused_mu_carry), .borrow(unused_mu_borrow)
   );

`ifdef KITCHEN_TIMER_ALARM_EN
   // set follows done, so an ack landing in the done cycle loses to the set
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         alarm <= 1'b0;
      end else if (done) begin
         alarm <= 1'b1;
      end else if (alarm_ack || clear || start_acc) begin
         alarm <= 1'b0;
      end
   end
`else
   logic unused_alarm_ack;
   assign unused_alarm_ack = alarm_ack;
   assign alarm            = 1'b0;
`endif

endmodule
